// File: rtl/fdiv_round_pack.sv
// fdiv_round_pack
// Back end of the floating-point divide path. Takes the raw fixed-point
// quotient from the mantissa divider, normalises it, rounds to nearest-even,
// forms the result exponent, resolves IEEE special operands and packs the
// final float. Two register stages with valid/ready backpressure.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   operand/quotient bundle valid
//   in_ready   stage can accept a bundle this cycle
//   sign_a/b   operand signs
//   exp_a/b    biased operand exponents
//   frac_nz_a/b operand fraction nonzero
//   quotient   unsigned quotient, bit WIDTH+4 has weight 2^0, value in [0.5,2)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   result     packed {sign, exponent, fraction}
//   flags      {invalid, div_by_zero, overflow, underflow, inexact}

module fdiv_round_pack #(
    parameter int WIDTH = 23,
    parameter int EXP_W = 8,
    parameter int BIAS  = 127
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sign_a,
    input  logic                   sign_b,
    input  logic [EXP_W-1:0]       exp_a,
    input  logic [EXP_W-1:0]       exp_b,
    input  logic                   frac_nz_a,
    input  logic                   frac_nz_b,
    input  logic [WIDTH+4:0]       quotient,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+WIDTH:0]   result,
    output logic [4:0]             flags
);

    localparam int EW = EXP_W + 2;

    localparam logic [EXP_W-1:0]       EXP_ONES = '1;
    localparam logic signed [EW-1:0]   BIAS_E   = EW'(BIAS);
    localparam logic signed [EW-1:0]   EMAX_E   = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0]   ZERO_E   = '0;
    localparam logic signed [EW-1:0]   ONE_E    = EW'(1);

    localparam logic [EXP_W+WIDTH:0]   QNAN =
        {1'b0, EXP_ONES, 1'b1, {(WIDTH-1){1'b0}}};

    typedef struct packed {
        logic                   sign;
        logic [WIDTH-1:0]       frac;
        logic                   g;
        logic                   s;
        logic signed [EW-1:0]   e;
        logic                   zero_a;
        logic                   inf_a;
        logic                   nan_a;
        logic                   zero_b;
        logic                   inf_b;
        logic                   nan_b;
    } s1_t;

    logic adv1;
    logic adv2;

    logic s1_valid_d, s1_valid_q;
    s1_t  s1_d, s1_q;
    s1_t  s1_new;

    logic                   s2_valid_d, s2_valid_q;
    logic [EXP_W+WIDTH:0]   result_d, result_q;
    logic [4:0]             flags_d, flags_q;

    logic [EXP_W+WIDTH:0]   res_calc;
    logic [4:0]             flg_calc;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign adv2      = !s2_valid_q || out_ready;
    assign adv1      = !s1_valid_q || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    // ------------------------------------------------------------------
    // Stage 1: normalise, exponent, operand classification
    // ------------------------------------------------------------------
    always_comb begin
        logic                   norm_hi;
        logic signed [EW-1:0]   ea_e;
        logic signed [EW-1:0]   eb_e;
        logic signed [EW-1:0]   dec_e;

        norm_hi = quotient[WIDTH+4];
        ea_e    = {2'b00, exp_a};
        eb_e    = {2'b00, exp_b};
        dec_e   = {{(EW-1){1'b0}}, ~norm_hi};

        s1_new = '0;
        s1_new.sign = sign_a ^ sign_b;
        if (norm_hi) begin
            s1_new.frac = quotient[WIDTH+3:4];
            s1_new.g    = quotient[3];
            s1_new.s    = |quotient[2:0];
        end else begin
            s1_new.frac = quotient[WIDTH+2:3];
            s1_new.g    = quotient[2];
            s1_new.s    = |quotient[1:0];
        end
        s1_new.e = ea_e - eb_e + BIAS_E - dec_e;

        // Subnormal operands are flushed to zero regardless of fraction.
        s1_new.zero_a = (exp_a == '0);
        s1_new.inf_a  = (exp_a == EXP_ONES) && !frac_nz_a;
        s1_new.nan_a  = (exp_a == EXP_ONES) &&  frac_nz_a;
        s1_new.zero_b = (exp_b == '0);
        s1_new.inf_b  = (exp_b == EXP_ONES) && !frac_nz_b;
        s1_new.nan_b  = (exp_b == EXP_ONES) &&  frac_nz_b;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d = s1_new;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round, range check, special cases, pack
    // ------------------------------------------------------------------
    always_comb begin
        logic                   rnd_up;
        logic [WIDTH:0]         frac_sum;
        logic [WIDTH-1:0]       frac_rnd;
        logic signed [EW-1:0]   e_rnd;
        logic                   inexact;
        logic                   sgn;

        sgn      = s1_q.sign;
        rnd_up   = s1_q.g && (s1_q.s || s1_q.frac[0]);
        frac_sum = {1'b0, s1_q.frac} + {{WIDTH{1'b0}}, rnd_up};
        inexact  = s1_q.g || s1_q.s;

        // A carry out means the fraction was all ones: mantissa becomes 2.0,
        // i.e. fraction zero with the exponent bumped.
        if (frac_sum[WIDTH]) begin
            frac_rnd = '0;
            e_rnd    = s1_q.e + ONE_E;
        end else begin
            frac_rnd = frac_sum[WIDTH-1:0];
            e_rnd    = s1_q.e;
        end

        res_calc = {sgn, e_rnd[EXP_W-1:0], frac_rnd};
        flg_calc = {4'b0000, inexact};

        if (e_rnd >= EMAX_E) begin
            res_calc = {sgn, EXP_ONES, {WIDTH{1'b0}}};
            flg_calc = 5'b00101;
        end else if (e_rnd <= ZERO_E) begin
            res_calc = {sgn, {(EXP_W+WIDTH){1'b0}}};
            flg_calc = 5'b00011;
        end

        // Special operands take priority over the arithmetic result.
        if (s1_q.nan_a || s1_q.nan_b) begin
            res_calc = QNAN;
            flg_calc = 5'b00000;
        end else if ((s1_q.zero_a && s1_q.zero_b) || (s1_q.inf_a && s1_q.inf_b)) begin
            res_calc = QNAN;
            flg_calc = 5'b10000;
        end else if (s1_q.zero_b && !s1_q.zero_a && !s1_q.inf_a) begin
            res_calc = {sgn, EXP_ONES, {WIDTH{1'b0}}};
            flg_calc = 5'b01000;
        end else if (s1_q.inf_a) begin
            // b is finite here (inf/inf and NaNs already handled); inf/0 lands here too.
            res_calc = {sgn, EXP_ONES, {WIDTH{1'b0}}};
            flg_calc = 5'b00000;
        end else if (s1_q.zero_a || s1_q.inf_b) begin
            res_calc = {sgn, {(EXP_W+WIDTH){1'b0}}};
            flg_calc = 5'b00000;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        flags_d    = flags_q;
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = res_calc;
                flags_d  = flg_calc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

endmodule

// File: doc/fdiv_round_pack.md
Name: fdiv_round_pack

Overview:
- Downstream stage of the mantissa divider in the floating-point divide path.
- Consumes the raw fixed-point quotient (integer bit plus guard bits) together with the operand signs, exponents and special-value info.
- Normalises, rounds to nearest-even, computes the result exponent, handles IEEE special cases, and packs the final float.
- Two-stage valid/ready pipeline with backpressure.

Parameters:
- WIDTH, 23, stored fraction bits.
- EXP_W, 8, exponent bits.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operand/quotient bundle valid
- in_ready  output  1  stage can accept the bundle this cycle
- sign_a, sign_b  input  1 each  operand signs
- exp_a, exp_b  input  EXP_W each  biased operand exponents
- frac_nz_a, frac_nz_b  input  1 each  operand fraction is nonzero
- quotient  input  WIDTH+5  unsigned quotient; bit WIDTH+4 has weight 2^0; value in [0.5,2)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  1+EXP_W+WIDTH  packed {sign, exponent, fraction}
- flags  output  5  {invalid, div_by_zero, overflow, underflow, inexact}

Behaviour:
- Reset (reset=0, asynchronous):
  - Both stage valid bits clear.
  - out_valid=0, result=0, flags=0.
  - Any in-flight operations are discarded.
- Handshake:
  - Transfer occurs on a cycle with in_valid&in_ready (input side) or out_valid&out_ready (output side).
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1, combinational from out_ready.
  - Stage registers load only when their advance signal is high.
  - out_valid=s2_valid. result and flags are registered and held stable while out_valid&!out_ready.
- Latency and throughput: 2 cycles from input accept to out_valid; one result per cycle when out_ready stays high.
- Stage 1, normalise/exponent:
  - If quotient[WIDTH+4]=1: frac=quotient[WIDTH+3:4], G=quotient[3], S=|quotient[2:0], dec=0.
  - Otherwise: frac=quotient[WIDTH+2:3], G=quotient[2], S=|quotient[1:0], dec=1.
  - e = exp_a - exp_b + BIAS - dec, computed signed in EXP_W+2 bits.
  - Classify each operand: zero (exp=0; subnormals are flushed to zero), inf (exp all-ones, !frac_nz), NaN (exp all-ones, frac_nz).
  - Register sign=sign_a^sign_b.
- Stage 2, round/pack:
  - Rounding:
    - Round up when G & (S | frac[0]).
    - A carry out of frac+1 sets frac=0 and e=e+1.
    - inexact = G|S.
  - Exponent range:
    - e >= 2^EXP_W-1: result = signed infinity; overflow=1, inexact=1.
    - e <= 0: result = signed zero; underflow=1, inexact=1. No subnormal output.
  - Special cases, in priority order; these override the arithmetic path and all other flags are 0:
    - Either operand NaN: result = qNaN (sign 0, exp all-ones, frac MSB 1, rest 0).
    - 0/0 or inf/inf: qNaN, invalid=1.
    - Finite nonzero / 0: signed infinity, div_by_zero=1.
    - inf / finite: signed infinity.
    - 0 / nonzero or finite / inf: signed zero.
- The quotient input is ignored for special cases; upstream may drive any value.
- Simultaneous accept and emit in the same cycle is legal and must not drop or duplicate data.

Test Plan:
- 6.0/3.0: exp_a=129, exp_b=128, quotient=1.0 (only bit 27 set) -> result 0x40000000, flags 0, out_valid exactly 2 cycles after accept.
- 1.0/1.5: exp_a=exp_b=127, quotient bits 26,24,…,0 set -> normalise path plus round-up -> 0x3F2AAAAB, inexact=1.
- Overflow and underflow:
  - exp_a=254, exp_b=1, quotient=1.0 -> 0x7F800000, overflow=1, inexact=1.
  - exp_a=1, exp_b=254 -> 0x00000000, underflow=1, inexact=1.
- Special cases:
  - 0/0 -> 0x7FC00000, invalid=1.
  - sign_a=1, 5.0/0 -> 0xFF800000, div_by_zero=1.
  - NaN/2.0 -> 0x7FC00000, flags 0.
- Backpressure:
  - Stream 4 back-to-back inputs with out_ready held 0 -> in_ready drops after 2 accepts; result stays stable.
  - Raise out_ready -> all 4 results emerge in order, none lost or duplicated.
- Reset mid-flight: assert reset with both stages valid -> out_valid=0, result=0 immediately; the first post-reset input produces the correct result 2 cycles later.
